// File: rtl/pixel_collector_if.sv
// rtl/pixel_collector_if.sv - raster-ordered result stream from the pixel collector
interface pixel_collector_if #(
  parameter int RESULT_WIDTH = 8
);
  logic [RESULT_WIDTH-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_sop;
  logic                    out_eop;

  modport master (
    output out_data,
    output out_valid,
    output out_sop,
    output out_eop,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_sop,
    input  out_eop,
    output out_ready
  );
endinterface

// File: rtl/pixel_collector.sv
// rtl/pixel_collector.sv - gathers one result per engine for a batch and streams them in raster order
module pixel_collector #(
  parameter int                          PIXEL_DATA_WIDTH = 10,
  parameter logic [PIXEL_DATA_WIDTH-1:0] SCREEN_WIDTH     = 10'd640,
  parameter logic [PIXEL_DATA_WIDTH-1:0] SCREEN_HEIGHT    = 10'd480,
  parameter int                          NUM_ENGINES      = 12,
  parameter int                          RESULT_WIDTH     = 8
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic [NUM_ENGINES-1:0]                    eng_done,
  input  logic [NUM_ENGINES-1:0][RESULT_WIDTH-1:0]  eng_result,
  pixel_collector_if.master                         stream,
  output logic                                      fin_flag
);
  localparam int IDX_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam logic [IDX_W-1:0]            LAST_IDX = IDX_W'(NUM_ENGINES - 1);
  localparam logic [PIXEL_DATA_WIDTH-1:0] X_LAST   = SCREEN_WIDTH - PIXEL_DATA_WIDTH'(1);
  localparam logic [PIXEL_DATA_WIDTH-1:0] Y_LAST   = SCREEN_HEIGHT - PIXEL_DATA_WIDTH'(1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                                  state;
  state_t                                  state_nxt;
  logic [NUM_ENGINES-1:0]                  done_q;
  logic [NUM_ENGINES-1:0]                  mask;
  logic [NUM_ENGINES-1:0]                  rise;
  logic [NUM_ENGINES-1:0][RESULT_WIDTH-1:0] buffer;
  logic [IDX_W-1:0]                        idx;
  logic [PIXEL_DATA_WIDTH-1:0]             x;
  logic [PIXEL_DATA_WIDTH-1:0]             y;
  logic                                    handshake;

  // Only a fresh 0->1 edge captures; a level held across batches is ignored.
  assign rise      = eng_done & ~done_q;
  assign handshake = (state == DRAIN) && stream.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    stream.out_valid = 1'b0;
    stream.out_data  = '0;
    stream.out_sop   = 1'b0;
    stream.out_eop   = 1'b0;
    fin_flag         = 1'b0;
    case (state)
      COLLECT: begin
        if (&(mask | rise)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        stream.out_valid = 1'b1;
        stream.out_data  = buffer[idx];
        stream.out_sop   = (x == '0) && (y == '0);
        stream.out_eop   = (x == X_LAST) && (y == Y_LAST);
        if (handshake && (idx == LAST_IDX)) begin
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        fin_flag  = 1'b1;
        state_nxt = COLLECT;
      end
      default: begin
        state_nxt = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q <= '0;
      mask   <= '0;
      buffer <= '0;
      idx    <= '0;
      x      <= '0;
      y      <= '0;
    end else begin
      done_q <= eng_done;
      case (state)
        COLLECT: begin
          mask <= mask | rise;
          for (int i = 0; i < NUM_ENGINES; i++) begin
            if (rise[i]) begin
              buffer[i] <= eng_result[i];
            end
          end
        end
        DRAIN: begin
          if (handshake) begin
            idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            // Raster position follows the stream, so a batch may straddle a frame edge.
            if (x == X_LAST) begin
              x <= '0;
              y <= (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
              x <= x + 1'b1;
            end
          end
        end
        RELEASE: begin
          mask <= '0;
          idx  <= '0;
        end
        default: begin
          mask <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pixel_collector.sv
// tb/tb_pixel_collector.sv - scoreboard bench for pixel_collector (12-engine VGA and 4-engine 8x2 instances)
module tb_pixel_collector;
  localparam int NA = 12;
  localparam int NB = 4;
  localparam int RW = 8;

  typedef struct packed {
    logic [RW-1:0] d;
    logic          sop;
    logic          eop;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [NA-1:0]         done_a = '0;
  logic [NA-1:0][RW-1:0] res_a = '0;
  logic                  fin_a;
  logic [NB-1:0]         done_b = '0;
  logic [NB-1:0][RW-1:0] res_b = '0;
  logic                  fin_b;

  pixel_collector_if #(.RESULT_WIDTH(RW)) ifa ();
  pixel_collector_if #(.RESULT_WIDTH(RW)) ifb ();

  pixel_collector #(
    .PIXEL_DATA_WIDTH(10), .SCREEN_WIDTH(10'd640), .SCREEN_HEIGHT(10'd480),
    .NUM_ENGINES(NA), .RESULT_WIDTH(RW)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .eng_done(done_a), .eng_result(res_a),
    .stream(ifa), .fin_flag(fin_a)
  );

  pixel_collector #(
    .PIXEL_DATA_WIDTH(10), .SCREEN_WIDTH(10'd8), .SCREEN_HEIGHT(10'd2),
    .NUM_ENGINES(NB), .RESULT_WIDTH(RW)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .eng_done(done_b), .eng_result(res_b),
    .stream(ifb), .fin_flag(fin_b)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t qa[$];
  exp_t qb[$];
  int   pos_a = 0;
  int   pos_b = 0;
  int   hs_a = 0;
  int   fin_cnt_a = 0;
  int   fin_cnt_b = 0;
  int   sop_cnt_b = 0;
  int   eop_cnt_b = 0;
  int   rdy_mode_a = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [RW-1:0] d, input int pos, input int w, input int h,
                              input bit last);
    exp_t r;
    r.d    = d;
    r.sop  = (pos == 0);
    r.eop  = (pos == w * h - 1);
    r.last = last;
    return r;
  endfunction

  // Ready pattern for instance A: 0 = always ready, 1 = alternate, 2 = stalled.
  initial begin
    ifa.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode_a)
        1:       ifa.out_ready = ~ifa.out_ready;
        2:       ifa.out_ready = 1'b0;
        default: ifa.out_ready = 1'b1;
      endcase
    end
  end

  logic       fin_due_a = 1'b0;
  logic       stall_a = 1'b0;
  logic [9:0] held_a = '0;
  exp_t       e_a;

  always @(negedge clk) begin
    if (!reset_n) begin
      stall_a   = 1'b0;
      fin_due_a = 1'b0;
    end else begin
      check("a_fin_flag", 32'(fin_a), 32'(fin_due_a));
      if (fin_a) fin_cnt_a++;
      fin_due_a = 1'b0;
      if (stall_a)
        check("a_stall_hold", 32'({ifa.out_valid, ifa.out_data, ifa.out_sop, ifa.out_eop}),
              32'({1'b1, held_a}));
      stall_a = ifa.out_valid && !ifa.out_ready;
      held_a  = {ifa.out_data, ifa.out_sop, ifa.out_eop};
      if (ifa.out_valid && ifa.out_ready) begin
        hs_a++;
        if (qa.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_extra_word: got data %0d with nothing expected, required no transfer", ifa.out_data);
        end else begin
          e_a = qa.pop_front();
          check("a_data", 32'(ifa.out_data), 32'(e_a.d));
          check("a_sop", 32'(ifa.out_sop), 32'(e_a.sop));
          check("a_eop", 32'(ifa.out_eop), 32'(e_a.eop));
          fin_due_a = e_a.last;
        end
      end
    end
  end

  logic fin_due_b = 1'b0;
  exp_t e_b;

  always @(negedge clk) begin
    if (!reset_n) begin
      fin_due_b = 1'b0;
    end else begin
      check("b_fin_flag", 32'(fin_b), 32'(fin_due_b));
      if (fin_b) fin_cnt_b++;
      fin_due_b = 1'b0;
      if (ifb.out_valid && ifb.out_ready) begin
        if (ifb.out_sop) sop_cnt_b++;
        if (ifb.out_eop) eop_cnt_b++;
        if (qb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_extra_word: got data %0d with nothing expected, required no transfer", ifb.out_data);
        end else begin
          e_b = qb.pop_front();
          check("b_data", 32'(ifb.out_data), 32'(e_b.d));
          check("b_sop", 32'(ifb.out_sop), 32'(e_b.sop));
          check("b_eop", 32'(ifb.out_eop), 32'(e_b.eop));
          fin_due_b = e_b.last;
        end
      end
    end
  end

  task automatic load_a(input logic [NA-1:0][RW-1:0] v);
    res_a = v;
    for (int i = 0; i < NA; i++) begin
      qa.push_back(mk(v[i], pos_a, 640, 480, i == NA - 1));
      pos_a = (pos_a + 1) % (640 * 480);
    end
  endtask

  task automatic raise_a(input bit all_at_once);
    if (all_at_once) begin
      done_a = '1;
      @(posedge clk); #1;
    end else begin
      for (int i = NA - 1; i >= 0; i--) begin
        done_a[i] = 1'b1;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_fin_a(output int cyc);
    cyc = 0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (fin_a) break;
    end
    checks++;
    if (!fin_a) begin
      errors++;
      $display("FAIL a_fin_timeout: no fin_flag after %0d cycles, required within 200", cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_batch_b(input int base);
    for (int i = 0; i < NB; i++) begin
      res_b[i] = RW'(base + i);
      qb.push_back(mk(RW'(base + i), pos_b, 8, 2, i == NB - 1));
      pos_b = (pos_b + 1) % 16;
    end
    done_b = '1;
    @(posedge clk); #1;
    done_b = '0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (fin_b) break;
    end
    checks++;
    if (!fin_b) begin
      errors++;
      $display("FAIL b_fin_timeout: no fin_flag within 50 cycles, required a pulse");
    end
    @(posedge clk); #1;
  endtask

  logic [NA-1:0][RW-1:0] v;
  int cyc;
  int base;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(ifa.out_valid), 0);
    check("rst_data", 32'(ifa.out_data), 0);
    check("rst_sop", 32'(ifa.out_sop), 0);
    check("rst_eop", 32'(ifa.out_eop), 0);
    check("rst_fin", 32'(fin_a), 0);
    check("rst_valid_b", 32'(ifb.out_valid), 0);
    reset_n = 1'b1;
    ifb.out_ready = 1'b1;
    @(posedge clk); #1;

    // T1: reverse-order completion, result 3*i, full ready
    for (int i = 0; i < NA; i++) v[i] = RW'(3 * i);
    base = hs_a;
    load_a(v);
    raise_a(1'b0);
    done_a = '0;
    wait_fin_a(cyc);
    check("t1_fin_cycle", 32'(cyc), 13);
    check("t1_words", 32'(hs_a - base), 12);

    // T2: alternating ready
    for (int i = 0; i < NA; i++) v[i] = RW'(8'h40 + 5 * i);
    rdy_mode_a = 1;
    base = hs_a;
    load_a(v);
    raise_a(1'b0);
    done_a = '0;
    wait_fin_a(cyc);
    check("t2_words", 32'(hs_a - base), 12);
    rdy_mode_a = 0;

    // T3: small screen, sop/eop across frame boundaries
    for (int b = 0; b < 5; b++) run_batch_b(10 + NB * b);
    check("t3_sop_count", 32'(sop_cnt_b), 2);
    check("t3_eop_count", 32'(eop_cnt_b), 1);
    check("t3_batches", 32'(fin_cnt_b), 5);

    // T4: held level on bit 2 and a drain-time edge on bit 0 must not capture
    rdy_mode_a = 2;
    for (int i = 0; i < NA; i++) v[i] = RW'(8'h10 + i);
    load_a(v);
    raise_a(1'b0);
    done_a = 12'h004;
    @(posedge clk); #1;
    res_a[0] = 8'hEE;
    done_a[0] = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rdy_mode_a = 0;
    wait_fin_a(cyc);
    for (int i = 0; i < NA; i++) v[i] = RW'(8'h80 + 7 * i);
    load_a(v);
    for (int i = 1; i < NA; i++) begin
      if (i != 2) begin
        done_a[i] = 1'b1;
        @(posedge clk); #1;
      end
    end
    repeat (4) begin
      check("t4_no_early_drain", 32'(ifa.out_valid), 0);
      @(posedge clk); #1;
    end
    done_a[0] = 1'b0;
    done_a[2] = 1'b0;
    @(posedge clk); #1;
    done_a[0] = 1'b1;
    done_a[2] = 1'b1;
    @(posedge clk); #1;
    check("t4_drain_after_edges", 32'(ifa.out_valid), 1);
    done_a = '0;
    wait_fin_a(cyc);

    // T5: all engines finish together
    for (int i = 0; i < NA; i++) v[i] = RW'(8'hF0 - 3 * i);
    load_a(v);
    check("t5_idle_before", 32'(ifa.out_valid), 0);
    raise_a(1'b1);
    check("t5_valid_next", 32'(ifa.out_valid), 1);
    done_a = '0;
    wait_fin_a(cyc);
    check("t5_fin_cycle", 32'(cyc), 13);

    // T6: reset after the 5th transfer discards the batch
    for (int i = 0; i < NA; i++) v[i] = RW'(8'h20 + i);
    base = hs_a;
    load_a(v);
    raise_a(1'b1);
    done_a = '0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (hs_a - base >= 5) break;
    end
    check("t6_five_words", 32'(hs_a - base), 5);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(ifa.out_valid), 0);
    check("t6_rst_fin", 32'(fin_a), 0);
    check("t6_rst_data", 32'(ifa.out_data), 0);
    qa.delete();
    pos_a = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NA; i++) v[i] = RW'(8'h60 + 2 * i);
    load_a(v);
    raise_a(1'b1);
    check("t6_first_sop", 32'(ifa.out_sop), 1);
    check("t6_first_data", 32'(ifa.out_data), 32'(8'h60));
    done_a = '0;
    wait_fin_a(cyc);

    repeat (3) begin @(posedge clk); #1; end
    check("a_fin_total", 32'(fin_cnt_a), 6);
    check("a_queue_empty", 32'(qa.size()), 0);
    check("b_queue_empty", 32'(qb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end
endmodule
